// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding and frame constants for the MAC transmit framer
package mac_pkg;
  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DROP, PRE, SFD, DST, SRC, LENF, PAY, PAD, FCS, IFG
  } state_t;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam int          HDR_BYTES     = 14;
endpackage

// File: rtl/crc32_byte.sv
// crc32_byte: one-byte step of the reflected CRC-32, unrolled over eight bit shifts
module crc32_byte
  import mac_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);
  // fold the byte into the low bits, then shift out one bit per step
  always_comb begin
    crc_next = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) crc_next = crc_next[0] ? (crc_next >> 1) ^ CRC_POLY : crc_next >> 1;
  end
endmodule

// File: rtl/mac_tx_framer.sv
// mac_tx_framer: wraps a length-prefixed byte stream into a full 802.3 frame with pad, FCS and gap
module mac_tx_framer
  import mac_pkg::*;
#(
  parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC     = 48'h020000000001,
  parameter int          MIN_PAYLOAD = 46,
  parameter int          MAX_PAYLOAD = 1500,
  parameter int          IFG_CYCLES  = 12
)(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic [7:0] s_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic [7:0] m_tdata,
  output logic       m_tlast,
  output logic       busy,
  output logic       frame_done,
  output logic       len_error
);
  state_t      state, state_n;
  logic [15:0] len, cnt, hdr;
  logic [7:0]  ifg_cnt;
  logic [31:0] crc, crc_next, fcs_sh;
  logic [47:0] dst_sh, src_sh;
  logic        rdy, xfer, hdr_bad;

  assign hdr      = {len[15:8], s_tdata};
  assign hdr_bad  = hdr == 16'd0 || hdr > 16'(MAX_PAYLOAD);
  assign s_tready = rdy && reset_n;
  assign xfer     = (m_tvalid && m_tready) || (s_tvalid && s_tready);
  assign busy     = state != IDLE;
  assign dst_sh   = DST_MAC >> (6'd40 - {cnt[2:0], 3'b000});
  assign src_sh   = SRC_MAC >> (6'd40 - {cnt[2:0], 3'b000});
  assign fcs_sh   = ~crc >> {cnt[1:0], 3'b000};

  crc32_byte u_crc (.crc(crc), .data(m_tdata), .crc_next(crc_next));

  // state register; async reset aborts any frame in flight
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;

  // next state and handshake/data outputs per field
  always_comb begin
    state_n  = state;
    rdy      = 1'b0;
    m_tvalid = 1'b0;
    m_tdata  = 8'h00;
    m_tlast  = 1'b0;
    case (state)
      IDLE, LEN_HI: begin
        rdy = 1'b1;
        if (s_tvalid) state_n = LEN_LO;
      end
      LEN_LO: begin
        rdy = 1'b1;
        if (s_tvalid) state_n = hdr == 16'd0 ? IDLE : hdr_bad ? DROP : PRE;
      end
      DROP: begin
        rdy = 1'b1;
        if (s_tvalid && cnt == len - 16'd1) state_n = IDLE;
      end
      PRE: begin
        m_tvalid = 1'b1;
        m_tdata  = PREAMBLE_BYTE;
        if (m_tready && cnt == 16'd6) state_n = SFD;
      end
      SFD: begin
        m_tvalid = 1'b1;
        m_tdata  = SFD_BYTE;
        if (m_tready) state_n = DST;
      end
      DST: begin
        m_tvalid = 1'b1;
        m_tdata  = dst_sh[7:0];
        if (m_tready && cnt == 16'd5) state_n = SRC;
      end
      SRC: begin
        m_tvalid = 1'b1;
        m_tdata  = src_sh[7:0];
        if (m_tready && cnt == 16'd5) state_n = LENF;
      end
      LENF: begin
        m_tvalid = 1'b1;
        m_tdata  = cnt[0] ? len[7:0] : len[15:8];
        if (m_tready && cnt == 16'd1) state_n = PAY;
      end
      PAY: begin
        m_tvalid = s_tvalid;
        rdy      = m_tready;
        m_tdata  = s_tdata;
        if (s_tvalid && m_tready && cnt == len - 16'd1) state_n = len < 16'(MIN_PAYLOAD) ? PAD : FCS;
      end
      PAD: begin
        m_tvalid = 1'b1;
        if (m_tready && cnt == 16'(MIN_PAYLOAD - 1)) state_n = FCS;
      end
      FCS: begin
        m_tvalid = 1'b1;
        m_tdata  = fcs_sh[7:0];
        m_tlast  = cnt == 16'd3;
        if (m_tready && cnt == 16'd3) state_n = IFG;
      end
      IFG: if (ifg_cnt == 8'(IFG_CYCLES - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // header capture, shared byte counter (payload count carries into pad), gap timer, CRC and pulses
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      len        <= '0;
      cnt        <= '0;
      ifg_cnt    <= '0;
      crc        <= CRC_INIT;
      frame_done <= 1'b0;
      len_error  <= 1'b0;
    end else begin
      frame_done <= state == FCS && m_tready && cnt == 16'd3;
      len_error  <= state == LEN_LO && s_tvalid && hdr_bad;
      if ((state == IDLE || state == LEN_HI) && s_tvalid) len[15:8] <= s_tdata;
      if (state == LEN_LO && s_tvalid) len[7:0] <= s_tdata;
      cnt     <= state_n != state ? (state_n == PAD ? cnt + 16'd1 : 16'd0) : xfer ? cnt + 16'd1 : cnt;
      ifg_cnt <= state == IFG ? ifg_cnt + 8'd1 : 8'd0;
      crc     <= state == SFD ? CRC_INIT :
                 (m_tvalid && m_tready && state inside {DST, SRC, LENF, PAY, PAD}) ? crc_next : crc;
    end
endmodule
